dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
Arbitrates the single data-memory port (4096 x 32-bit words, byte-enabled, combinational read, write on posedge clk) between two masters. Master 0 is the CPU MEM stage; master 1 is a secondary master (loader/debug/DMA).
- Round-robin arbitration with optional short locked bursts.
- Address-range checking.
- Sits directly in front of the data memory; the DM write strobe, address, byte enables and write data come only from this block.

Parameters:
ADDR_LIMIT, 32'h0000_4000, first byte address outside DM; any beat with addr >= ADDR_LIMIT is an error.
MAX_BURST, 4, maximum consecutive beats one master may hold under lock (range 2..16).

Ports:
clk  in  1  system clock, posedge
reset  in  1  asynchronous, active-high reset
m0_req  in  1  master 0 beat request
m0_we  in  1  master 0 write
m0_lock  in  1  master 0 requests to keep ownership after this beat
m0_addr  in  32  master 0 byte address
m0_be  in  4  master 0 byte enables
m0_wd  in  32  master 0 write data
m0_gnt  out  1  master 0 beat accepted this cycle
m0_rdata  out  32  master 0 read data, valid when m0_gnt
m0_err  out  1  master 0 beat out of range, valid when m0_gnt
m1_*  same set as m0_*, for master 1
dm_we  out  1  DM write enable
dm_addr  out  32  DM byte address
dm_be  out  4  DM byte enables
dm_wd  out  32  DM write data
dm_rdata  in  32  DM combinational read data
owner  out  1  id of the master granted this cycle; 0 when idle
err_sticky  out  1  set by any error beat, cleared only by reset
stat_gnt0  out  32  optional-feature counter
stat_gnt1  out  32  optional-feature counter
stat_conflict  out  32  optional-feature counter

Behaviour:
- Registered state:
  - st: IDLE, LOCK0, LOCK1
  - last: id of the master served most recently
  - bcnt: beats taken so far in the current lock
  - err_sticky
  - stats counters
- Reset (asynchronous, immediate, including mid-lock): st=IDLE, last=1 (master 0 wins the first conflict), bcnt=0, err_sticky=0, stats=0.
- Grant is combinational and single-cycle.
  - A beat completes in the cycle where mX_req && mX_gnt.
  - Reads return dm_rdata in that same cycle.
  - Writes land at the next posedge.
  - No buffering; a master that is not granted must hold its request.
- Arbitration:
  - IDLE, or LOCKx with mx_req=0: if only one master requests, it is granted. If both request, the master != last is granted. If neither requests, nothing is granted.
  - LOCKx with mx_req=1: master x is granted; the other master is blocked.
- Next state, evaluated on a granted beat by master g:
  - last <= g.
  - If mg_lock=1 and the beat number (bcnt+1) < MAX_BURST: st <= LOCKg, bcnt <= bcnt+1.
  - Otherwise: st <= IDLE, bcnt <= 0. Reaching MAX_BURST forces release; since last=g, the other master wins the next conflict.
  - In LOCKx with no grant to x (mx_req=0): st <= IDLE, bcnt <= 0, even if the other master is granted that cycle. If the other master is granted with its lock set, st <= LOCK of that master per the rule above.
- DM drive:
  - Granted beat: dm_addr/dm_be/dm_wd come from the granted master. dm_we = we && !err.
  - No grant: dm_we=0, dm_addr=0, dm_be=0, dm_wd=0.
- Error (addr >= ADDR_LIMIT):
  - The beat is still granted and consumed.
  - mX_err=1, dm_we=0, mX_rdata=0.
  - err_sticky <= 1 at the next posedge.
  - Lock and state rules apply unchanged.
- Outputs when not granted: mX_gnt=0, mX_rdata=0, mX_err=0.
- The arbiter never modifies the byte-enable pattern; be=0 writes pass through with dm_we=1.

Optional Feature:
DM_ARB_STATS_EN
- Defined:
  - stat_gnt0 / stat_gnt1 increment on each granted beat of master 0 / master 1.
  - stat_conflict increments on each cycle where both masters request.
  - All three counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: counters are not built; the three ports remain and are driven 0.

Test Plan:
- m0 write addr 0x10, be=4'b0011, wd=0xAABBCCDD, m1 idle -> m0_gnt=1 same cycle, dm_we=1, dm_addr=0x10, owner=0. Next-cycle m0 read of 0x10 returns DM word with low half 0xCCDD.
- Both request every cycle with no lock, starting from reset -> grants alternate 0,1,0,1. With stats enabled: stat_conflict=4 and stat_gnt0=stat_gnt1=2 after 4 cycles.
- m1 holds lock=1 and req=1 for 6 cycles while m0 requests continuously, MAX_BURST=4 -> m1 granted 4 beats, m0 granted on the 5th cycle, m1 on the 6th.
- m0 locked in LOCK0 then drops req while m1 requests -> m1 granted that cycle, st returns to IDLE.
- m1 write to addr 0x4000 -> m1_gnt=1, m1_err=1, dm_we=0, DM unchanged, err_sticky=1 next cycle.
- Assert reset mid-burst (LOCK1, bcnt=2) -> outputs cleared immediately. After release, a conflict grants master 0 first.

Source files
------------

// File: rtl/dm_arbiter.sv
// Two-master round-robin arbiter with short locked bursts and address-range checking in front of the data memory.
// Optional grant/conflict counters are built only when DM_ARB_STATS_EN is defined.
module dm_arbiter #(
   parameter logic [31:0] ADDR_LIMIT = 32'h0000_4000,
   parameter int          MAX_BURST  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic        m0_lock,
   input  logic [31:0] m0_addr,
   input  logic [3:0]  m0_be,
   input  logic [31:0] m0_wd,
   output logic        m0_gnt,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic        m1_lock,
   input  logic [31:0] m1_addr,
   input  logic [3:0]  m1_be,
   input  logic [31:0] m1_wd,
   output logic        m1_gnt,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_wd,
   input  logic [31:0] dm_rdata,
   output logic        owner,
   output logic        err_sticky,
   output logic [31:0] stat_gnt0,
   output logic [31:0] stat_gnt1,
   output logic [31:0] stat_conflict
);

   // state | meaning
   // IDLE  | no lock held; plain round-robin between requesters
   // LOCK0 | master 0 holds the port while it keeps requesting
   // LOCK1 | master 1 holds the port while it keeps requesting
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } st_t;

   localparam int BW = $clog2(MAX_BURST + 1);

   st_t            st, st_n;
   logic           last, last_n;
   logic [BW-1:0]  bcnt, bcnt_n;
   logic           g0, g1, gnt, gid;
   logic           err0, err1;
   logic           g_we, g_lock, g_err;
   logic [31:0]    g_addr, g_wd;
   logic [3:0]     g_be;
   logic [31:0]    beat;

   assign err0 = (m0_addr >= ADDR_LIMIT);
   assign err1 = (m1_addr >= ADDR_LIMIT);

   always_comb begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (st == LOCK0 && m0_req) begin
         g0 = 1'b1;
      end else if (st == LOCK1 && m1_req) begin
         g1 = 1'b1;
      end else if (m0_req && m1_req) begin
         if (last) g0 = 1'b1;
         else      g1 = 1'b1;
      end else begin
         g0 = m0_req;
         g1 = m1_req;
      end
   end

   assign gnt    = g0 | g1;
   assign gid    = g1;
   assign g_we   = gid ? m1_we   : m0_we;
   assign g_lock = gid ? m1_lock : m0_lock;
   assign g_err  = gid ? err1    : err0;
   assign g_addr = gid ? m1_addr : m0_addr;
   assign g_be   = gid ? m1_be   : m0_be;
   assign g_wd   = gid ? m1_wd   : m0_wd;

   // A grant to the non-locking master starts a fresh burst count for it.
   always_comb begin
      st_n   = IDLE;
      bcnt_n = '0;
      last_n = last;
      beat   = 32'd1;
      if (gnt) begin
         last_n = gid;
         if ((st == LOCK0 && !gid) || (st == LOCK1 && gid))
            beat = 32'(bcnt) + 32'd1;
         if (g_lock && (beat < $unsigned(MAX_BURST))) begin
            st_n   = gid ? LOCK1 : LOCK0;
            bcnt_n = BW'(beat);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st         <= IDLE;
         last       <= 1'b1;
         bcnt       <= '0;
         err_sticky <= 1'b0;
      end else begin
         st         <= st_n;
         last       <= last_n;
         bcnt       <= bcnt_n;
         err_sticky <= err_sticky | (gnt & g_err);
      end
   end

   assign m0_gnt   = g0;
   assign m1_gnt   = g1;
   assign m0_err   = g0 & err0;
   assign m1_err   = g1 & err1;
   assign m0_rdata = (g0 && !err0) ? dm_rdata : 32'd0;
   assign m1_rdata = (g1 && !err1) ? dm_rdata : 32'd0;
   assign owner    = g1;

   assign dm_we   = gnt & g_we & ~g_err;
   assign dm_addr = gnt ? g_addr : 32'd0;
   assign dm_be   = gnt ? g_be   : 4'd0;
   assign dm_wd   = gnt ? g_wd   : 32'd0;

`ifdef DM_ARB_STATS_EN
   logic [31:0] s_gnt0, s_gnt1, s_conf;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_gnt0 <= 32'd0;
         s_gnt1 <= 32'd0;
         s_conf <= 32'd0;
      end else begin
         if (g0 && s_gnt0 != 32'hFFFF_FFFF) s_gnt0 <= s_gnt0 + 32'd1;
         if (g1 && s_gnt1 != 32'hFFFF_FFFF) s_gnt1 <= s_gnt1 + 32'd1;
         if (m0_req && m1_req && s_conf != 32'hFFFF_FFFF) s_conf <= s_conf + 32'd1;
      end
   end

   assign stat_gnt0     = s_gnt0;
   assign stat_gnt1     = s_gnt1;
   assign stat_conflict = s_conf;
`else
   assign stat_gnt0     = 32'd0;
   assign stat_gnt1     = 32'd0;
   assign stat_conflict = 32'd0;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus randomized traffic against a behavioural arbitration/memory model.
module tb_dm_arbiter;

   localparam int          MAXB  = 4;
   localparam logic [31:0] LIMIT = 32'h0000_4000;
`ifdef DM_ARB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
   logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
   logic [3:0]  m0_be, m1_be;
   logic        m0_gnt, m0_err, m1_gnt, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        dm_we, owner, err_sticky;
   logic [31:0] dm_addr, dm_wd, dm_rdata;
   logic [3:0]  dm_be;
   logic [31:0] stat_gnt0, stat_gnt1, stat_conflict;

   always #5 clk = ~clk;

   dm_arbiter #(.ADDR_LIMIT(LIMIT), .MAX_BURST(MAXB)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
      .m0_be(m0_be), .m0_wd(m0_wd), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
      .m1_be(m1_be), .m1_wd(m1_wd), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wd(dm_wd), .dm_rdata(dm_rdata),
      .owner(owner), .err_sticky(err_sticky),
      .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_conflict(stat_conflict)
   );

   // Data memory behind the arbiter
   logic [31:0] dm_mem [4096];
   logic        mem_init;
   assign dm_rdata = dm_mem[dm_addr[13:2]];

   function automatic logic [31:0] init_word(int i);
      return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 4096; i++) dm_mem[i] <= init_word(i);
      end else if (dm_we) begin
         for (int b = 0; b < 4; b++)
            if (dm_be[b]) dm_mem[dm_addr[13:2]][8*b +: 8] <= dm_wd[8*b +: 8];
      end
   end

   int pass_cnt = 0;
   int chk_cnt  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   // Reference model
   logic [31:0] ref_mem [4096];
   int          m_last, m_lock, m_beats;
   bit          m_sticky;
   int unsigned m_s0, m_s1, m_sc;
   logic        obs_g1;

   task automatic model_reset();
      m_last = 1; m_lock = -1; m_beats = 0; m_sticky = 0;
      m_s0 = 0; m_s1 = 0; m_sc = 0;
   endtask

   task automatic idle();
      m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_be = 0; m0_wd = 0;
      m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_be = 0; m1_wd = 0;
   endtask

   task automatic set_m(input int m, input bit req, input bit we, input bit lk,
                        input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
      if (m == 0) begin
         m0_req = req; m0_we = we; m0_lock = lk; m0_addr = a; m0_be = be; m0_wd = wd;
      end else begin
         m1_req = req; m1_we = we; m1_lock = lk; m1_addr = a; m1_be = be; m1_wd = wd;
      end
   endtask

   task automatic do_reset(input bit init);
      idle();
      reset = 1'b1;
      mem_init = init;
      repeat (2) @(negedge clk);
      mem_init = 1'b0;
      reset = 1'b0;
      if (init) for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
      model_reset();
   endtask

   // Called just after a falling edge with inputs applied; checks this cycle, advances the model at the rising edge.
   task automatic step();
      int g;
      bit both, we, lk, er;
      logic [31:0] a, wd, rd;
      logic [3:0] be;
      #1;
      both = m0_req && m1_req;
      if (m_lock == 0 && m0_req)      g = 0;
      else if (m_lock == 1 && m1_req) g = 1;
      else if (both)                  g = (m_last == 1) ? 0 : 1;
      else if (m0_req)                g = 0;
      else if (m1_req)                g = 1;
      else                            g = -1;
      we = (g == 1) ? m1_we   : m0_we;
      lk = (g == 1) ? m1_lock : m0_lock;
      a  = (g == 1) ? m1_addr : m0_addr;
      be = (g == 1) ? m1_be   : m0_be;
      wd = (g == 1) ? m1_wd   : m0_wd;
      er = (g >= 0) && (a >= LIMIT);
      rd = (g >= 0 && !er) ? ref_mem[a[13:2]] : 32'd0;
      obs_g1 = m1_gnt;

      check("m0_gnt",   32'(m0_gnt),   32'(g == 0));
      check("m1_gnt",   32'(m1_gnt),   32'(g == 1));
      check("owner",    32'(owner),    32'(g == 1));
      check("dm_we",    32'(dm_we),    32'(g >= 0 && we && !er));
      check("dm_addr",  dm_addr,       (g >= 0) ? a  : 32'd0);
      check("dm_be",    32'(dm_be),    (g >= 0) ? 32'(be) : 32'd0);
      check("dm_wd",    dm_wd,         (g >= 0) ? wd : 32'd0);
      check("m0_rdata", m0_rdata,      (g == 0) ? rd : 32'd0);
      check("m1_rdata", m1_rdata,      (g == 1) ? rd : 32'd0);
      check("m0_err",   32'(m0_err),   32'(g == 0 && er));
      check("m1_err",   32'(m1_err),   32'(g == 1 && er));
      check("err_sticky", 32'(err_sticky), 32'(m_sticky));
      check("stat_gnt0", stat_gnt0,    STATS ? m_s0 : 32'd0);
      check("stat_gnt1", stat_gnt1,    STATS ? m_s1 : 32'd0);
      check("stat_conflict", stat_conflict, STATS ? m_sc : 32'd0);

      @(posedge clk);
      if (both) m_sc++;
      if (g >= 0) begin
         if (g == 0) m_s0++; else m_s1++;
         m_beats = (m_lock == g) ? m_beats + 1 : 1;
         m_last  = g;
         if (lk && m_beats < MAXB) m_lock = g;
         else begin m_lock = -1; m_beats = 0; end
         if (er) m_sticky = 1;
         if (we && !er)
            for (int b = 0; b < 4; b++)
               if (be[b]) ref_mem[a[13:2]][8*b +: 8] = wd[8*b +: 8];
      end else begin
         m_lock = -1; m_beats = 0;
      end
      @(negedge clk);
   endtask

   initial begin
      logic [5:0] seq;
      do_reset(1'b1);

      // Reset state with nobody requesting
      step();

      // Write then read back through master 0
      set_m(0, 1, 1, 0, 32'h10, 4'b0011, 32'hAABB_CCDD);
      step();
      set_m(0, 1, 0, 0, 32'h10, 4'hF, 32'd0);
      #1 check("rd_low_half", 32'(m0_rdata[15:0]), 32'h0000_CCDD);
      step();

      // Plain conflicts alternate from reset
      do_reset(1'b0);
      set_m(0, 1, 0, 0, 32'h20, 4'hF, 32'd0);
      set_m(1, 1, 0, 0, 32'h24, 4'hF, 32'd0);
      seq = '0;
      for (int i = 0; i < 4; i++) begin step(); seq[i] = obs_g1; end
      check("alt_seq", 32'(seq[3:0]), 32'b1010);
      if (STATS) begin
         check("alt_conflict", stat_conflict, 32'd4);
         check("alt_gnt0", stat_gnt0, 32'd2);
         check("alt_gnt1", stat_gnt1, 32'd2);
      end

      // Locked burst capped at MAXB beats
      do_reset(1'b0);
      set_m(0, 1, 0, 0, 32'h30, 4'hF, 32'd0);
      step();
      set_m(1, 1, 1, 1, 32'h40, 4'hF, 32'h1234_5678);
      seq = '0;
      for (int i = 0; i < 6; i++) begin
         m1_wd = 32'h1000 + 32'(i);
         step();
         seq[i] = obs_g1;
      end
      check("burst_seq", 32'(seq), 32'b101111);

      // Lock holder drops its request: other master served, lock released
      idle();
      set_m(0, 1, 0, 1, 32'h50, 4'hF, 32'd0);
      step();
      set_m(0, 0, 0, 0, 32'h0, 4'h0, 32'd0);
      set_m(1, 1, 0, 0, 32'h54, 4'hF, 32'd0);
      step();
      set_m(0, 1, 0, 0, 32'h58, 4'hF, 32'd0);
      step();
      check("unlock_next_m0", 32'(obs_g1), 32'd0);

      // Out-of-range write is consumed but never reaches memory
      idle();
      set_m(1, 1, 1, 0, 32'h4000, 4'hF, 32'hDEAD_BEEF);
      step();
      idle();
      set_m(0, 1, 0, 0, 32'h0, 4'hF, 32'd0);
      step();

      // Asynchronous reset in the middle of a master 1 burst
      do_reset(1'b0);
      idle();
      set_m(1, 1, 0, 1, 32'h5000, 4'hF, 32'd0);
      step();
      set_m(1, 1, 0, 1, 32'h60, 4'hF, 32'd0);
      set_m(0, 1, 0, 0, 32'h64, 4'hF, 32'd0);
      step();
      #2 reset = 1'b1;
      #1;
      check("rst_gnt0", 32'(m0_gnt), 32'd1);
      check("rst_gnt1", 32'(m1_gnt), 32'd0);
      check("rst_sticky", 32'(err_sticky), 32'd0);
      if (STATS) check("rst_stats", stat_gnt0 | stat_gnt1 | stat_conflict, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      set_m(1, 1, 0, 0, 32'h68, 4'hF, 32'd0);
      step();
      check("post_rst_first", 32'(obs_g1), 32'd0);

      // Randomized traffic
      for (int c = 0; c < 600; c++) begin
         for (int m = 0; m < 2; m++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? (LIMIT + 32'($urandom_range(0, 32'h3FFF)))
                                            : 32'($urandom_range(0, 63)) << 2;
            set_m(m, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) != 0, a, 4'($urandom_range(0, 15)), $urandom);
         end
         step();
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
